// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA framebuffer path.
//   fetch_state_e : line-fetch FSM states
//   H_DISP_DEF / V_DISP_DEF : default visible geometry
//   clog2()       : index width helper, never returns less than 1
package vga_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    localparam int H_DISP_DEF = 1280;
    localparam int V_DISP_DEF = 1024;

    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rd_tag_pipe.sv
// Tag delay line for framebuffer reads: RD_LAT stages of {valid, bank, index, live}.
//   in_*   : tag of the read strobe currently on the RAM port
//   kill_i : clears live on every stage, including the tag entering this cycle
//   out_*  : tag aligned with the RAM read data
//   pend_o : a read is still in flight behind the output stage
module rd_tag_pipe #(
    parameter int RD_LAT = 2,
    parameter int IDX_W  = 9
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             in_vld_i,
    input  logic             in_bank_i,
    input  logic [IDX_W-1:0] in_idx_i,
    input  logic             kill_i,
    output logic             out_vld_o,
    output logic             out_live_o,
    output logic             out_bank_o,
    output logic [IDX_W-1:0] out_idx_o,
    output logic             pend_o
);

    logic [RD_LAT-1:0]            vld_q, live_q, bank_q;
    logic [RD_LAT-1:0][IDX_W-1:0] idx_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q  <= '0;
            live_q <= '0;
            bank_q <= '0;
            idx_q  <= '0;
        end else begin
            vld_q[0]  <= in_vld_i;
            live_q[0] <= in_vld_i && !kill_i;
            bank_q[0] <= in_bank_i;
            idx_q[0]  <= in_idx_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                live_q[i] <= live_q[i-1] && !kill_i;
                bank_q[i] <= bank_q[i-1];
                idx_q[i]  <= idx_q[i-1];
            end
        end
    end

    // The output stage is being consumed this cycle, so only earlier stages count as pending.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < RD_LAT - 1; i++) pend_o = pend_o | vld_q[i];
    end

    assign out_vld_o  = vld_q[RD_LAT-1];
    assign out_live_o = live_q[RD_LAT-1];
    assign out_bank_o = bank_q[RD_LAT-1];
    assign out_idx_o  = idx_q[RD_LAT-1];

endmodule

// File: rtl/fb_line_scheduler.sv
// Framebuffer port scheduler: shares the single RAM port between the display line
// prefetch (into a ping-pong line buffer) and the pixel writer.
//   frame_start_i / line_start_i : timing events from the sync generator
//   wr_*                         : writer request, accepted on wr_valid_i && wr_ready_o
//   mem_*                        : registered RAM port, mem_rdata_i returns RD_LAT cycles later
//   lb_*                         : line buffer write port
//   disp_bank_o                  : bank the pixel mux shows
//   fetch_busy_o / underrun_o    : fetch status
// Optional macro FB_ARB_FAIR_EN: alternate grants when fetch and writer contend.
module fb_line_scheduler
    import vga_pkg::*;
#(
    parameter  int H_DISP       = H_DISP_DEF,
    parameter  int V_DISP       = V_DISP_DEF,
    parameter  int PIX_PER_WORD = 4,
    parameter  int DATA_W       = 32,
    parameter  int ADDR_W       = 19,
    parameter  int RD_LAT       = 2,
    localparam int WPL          = H_DISP / PIX_PER_WORD,
    localparam int LB_AW        = clog2(WPL),
    localparam int K_W          = clog2(V_DISP + 1)
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              frame_start_i,
    input  logic              line_start_i,
    input  logic              wr_valid_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              lb_we_o,
    output logic              lb_bank_o,
    output logic [LB_AW-1:0]  lb_addr_o,
    output logic [DATA_W-1:0] lb_wdata_o,
    output logic              disp_bank_o,
    output logic              fetch_busy_o,
    output logic              underrun_o
);

    fetch_state_e      state_q;
    logic [K_W-1:0]    k_q, k_d;
    logic              fb_q, fb_d;
    logic [ADDR_W-1:0] base_q, base_d, rd_addr;
    logic [LB_AW-1:0]  w_q, w_cur, tag_idx_q;
    logic              disp_bank_q, underrun_q, tag_bank_q;
    logic              mem_req_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              start, kill, fetch_want, fetch_gnt, wr_gnt, more_lines;
    logic              rd_strobe, pend, pipe_vld, pipe_live, pipe_bank;
    logic [LB_AW-1:0]  pipe_idx;

`ifdef FB_ARB_FAIR_EN
    logic fetch_turn_q;
`endif

    assign more_lines = (int'(k_q) + 1) < V_DISP;
    assign rd_strobe  = mem_req_q && !mem_we_q;

    // A fetch start issues word 0 in the pulse cycle itself, using the new line's
    // base and bank, so the first strobe lands one cycle after the pulse.
    always_comb begin
        k_d    = k_q;
        fb_d   = fb_q;
        base_d = base_q;
        start  = 1'b0;
        if (frame_start_i) begin
            k_d    = '0;
            fb_d   = 1'b0;
            base_d = '0;
            start  = 1'b1;
        end else if (line_start_i && more_lines) begin
            k_d    = k_q + K_W'(1);
            fb_d   = ~fb_q;
            base_d = base_q + ADDR_W'(WPL);
            start  = 1'b1;
        end
        kill       = (frame_start_i || line_start_i) && (state_q != IDLE);
        // A killed fetch with no successor must not issue another read of the old line.
        fetch_want = start || (state_q == ISSUE && !kill);
`ifdef FB_ARB_FAIR_EN
        fetch_gnt  = fetch_want && (start || !wr_valid_i || fetch_turn_q);
`else
        fetch_gnt  = fetch_want;
`endif
        wr_gnt     = wr_valid_i && !fetch_gnt;
        w_cur      = start ? '0 : w_q;
        rd_addr    = base_d + ADDR_W'(w_cur);
    end

    // Gated by reset so the writer never sees a grant while the block is held in reset.
    assign wr_ready_o = wr_gnt && rst_n_i;

`ifdef FB_ARB_FAIR_EN
    // On a contended cycle the loser gets the next one; a fetch start always wins.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)                      fetch_turn_q <= 1'b1;
        else if (fetch_want && wr_valid_i) fetch_turn_q <= wr_gnt;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= IDLE;
            k_q         <= K_W'(V_DISP);
            fb_q        <= 1'b0;
            base_q      <= '0;
            w_q         <= '0;
            disp_bank_q <= 1'b0;
            underrun_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            tag_bank_q  <= 1'b0;
            tag_idx_q   <= '0;
        end else begin
            k_q        <= k_d;
            fb_q       <= fb_d;
            base_q     <= base_d;
            underrun_q <= kill;
            if (line_start_i && !frame_start_i) disp_bank_q <= fb_q;
            mem_req_q   <= fetch_gnt || wr_gnt;
            mem_we_q    <= wr_gnt;
            mem_addr_q  <= fetch_gnt ? rd_addr : (wr_gnt ? wr_addr_i : '0);
            mem_wdata_q <= wr_gnt ? wr_data_i : '0;
            tag_bank_q  <= fb_d;
            tag_idx_q   <= w_cur;
            if (kill && !start) begin
                state_q <= IDLE;
            end else if (fetch_gnt) begin
                w_q     <= w_cur + LB_AW'(1);
                state_q <= (w_cur == LB_AW'(WPL - 1)) ? DRAIN : ISSUE;
            end else if (state_q == DRAIN && !rd_strobe && !pend) begin
                state_q <= IDLE;
            end
        end
    end

    rd_tag_pipe #(.RD_LAT(RD_LAT), .IDX_W(LB_AW)) u_tag_pipe (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .in_vld_i   (rd_strobe),
        .in_bank_i  (tag_bank_q),
        .in_idx_i   (tag_idx_q),
        .kill_i     (kill),
        .out_vld_o  (pipe_vld),
        .out_live_o (pipe_live),
        .out_bank_o (pipe_bank),
        .out_idx_o  (pipe_idx),
        .pend_o     (pend)
    );

    assign lb_we_o      = pipe_vld && pipe_live;
    assign lb_bank_o    = lb_we_o && pipe_bank;
    assign lb_addr_o    = lb_we_o ? pipe_idx : '0;
    assign lb_wdata_o   = lb_we_o ? mem_rdata_i : '0;
    assign mem_req_o    = mem_req_q;
    assign mem_we_o     = mem_we_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign disp_bank_o  = disp_bank_q;
    assign fetch_busy_o = (state_q != IDLE);
    assign underrun_o   = underrun_q;

endmodule

// File: doc/fb_line_scheduler.md
# fb_line_scheduler

Framebuffer access scheduler for the VGA output path. It owns the single port of the on-chip framebuffer RAM and shares it between two requesters. One is the display line prefetch, which copies the next visible line into a ping-pong line buffer. The other is a pixel writer (the drawing side). It sits between the sync/blank timing generator, which supplies line/frame events, and the pixel mux, which reads the line buffer bank selected by `disp_bank`.

## Interface
- `H_DISP`, 1280: visible pixels per line.
- `V_DISP`, 1024: visible lines per frame.
- `PIX_PER_WORD`, 4: pixels per framebuffer word. `WPL = H_DISP/PIX_PER_WORD` words per line.
- `DATA_W`, 32: framebuffer word width.
- `ADDR_W`, 19: word address width. Must satisfy `WPL*V_DISP <= 2**ADDR_W`.
- `RD_LAT`, 2: fixed read latency of the RAM, in cycles (≥1).

- `clk`  in  1  pixel clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  one-cycle pulse in vertical blank, before the first `line_start` of a frame.
- `line_start`  in  1  one-cycle pulse in horizontal blank, before each visible line.
- `wr_valid`  in  1  writer request.
- `wr_addr`  in  ADDR_W  writer word address.
- `wr_data`  in  DATA_W  writer word.
- `wr_ready`  out  1  writer granted this cycle. A transfer occurs when `wr_valid && wr_ready`.
- `mem_req`  out  1  RAM access strobe.
- `mem_we`  out  1  1 = write, 0 = read.
- `mem_addr`  out  ADDR_W  RAM word address.
- `mem_wdata`  out  DATA_W  RAM write data.
- `mem_rdata`  in  DATA_W  RAM read data, valid `RD_LAT` cycles after a read strobe.
- `lb_we`  out  1  line buffer write strobe.
- `lb_bank`  out  1  line buffer bank being written.
- `lb_addr`  out  clog2(WPL)  word index within the line.
- `lb_wdata`  out  DATA_W  line buffer data.
- `disp_bank`  out  1  bank the pixel mux must display.
- `fetch_busy`  out  1  a line fetch is issuing reads or draining.
- `underrun`  out  1  one-cycle pulse when `line_start` arrives while a fetch is still busy.

## Operation
- Line counter `k` (0..V_DISP), fetch bank `fb`, word index `w`, running base address `base`. Base is advanced by `WPL` per line; no multiplier.
- `frame_start`:
  - k←0, fb←0, base←0.
  - Start fetch of line 0 into bank 0.
- `line_start`:
  - disp_bank←fb (the bank just filled).
  - If k+1<V_DISP: k←k+1, fb←~fb, base←base+WPL, start fetch of line k+1.
  - Otherwise, no fetch until the next `frame_start`.
- FSM states:
  - IDLE → ISSUE on fetch start.
  - ISSUE: one read per granted cycle at `base+w`, w←w+1. → DRAIN after word WPL-1 is issued.
  - DRAIN: wait for the `RD_LAT` pipe to empty → IDLE.
- Read return:
  - A delay line of `RD_LAT` stages carries {valid, bank, index, live}.
  - `lb_we` is asserted only for returning reads with live=1.
- Underrun (`line_start` or `frame_start` while not IDLE):
  - Pulse `underrun`.
  - Mark all in-flight reads live=0.
  - Restart ISSUE for the new line at w=0 on the next cycle.
- Arbitration: one RAM access per cycle.
  - Without the fairness feature, fetch (ISSUE) has strict priority.
  - The writer is granted in every cycle where fetch is not issuing.
- `fetch_busy` = (state≠IDLE).
- `frame_start` and `line_start` in the same cycle: `frame_start` wins and `line_start` is ignored.
- Reset values: all outputs 0, state IDLE, k=V_DISP (no fetch until `frame_start`), delay line cleared.

## Timing
- `mem_*` outputs are registered.
  - Grant decision in cycle t gives `mem_req` in cycle t+1.
  - `wr_ready` is combinational from state and `wr_valid`; data is captured into `mem_wdata` on the accepting edge.
- Fetch start: first read strobe 1 cycle after the `frame_start`/`line_start` pulse.
- First `lb_we` appears `RD_LAT` cycles after its read strobe.
- Uncontended fetch takes WPL+RD_LAT+1 cycles (323 with defaults), well inside a 1688-cycle line.
- Reset mid-fetch: outputs drop to reset values at once. No `lb_we` is issued for reads still in flight.

## Configuration
- `FB_ARB_FAIR_EN`:
  - Defined: when both fetch and writer request, grants alternate. The first contended cycle goes to fetch.
  - Defined: worst-case fetch becomes 2·WPL+RD_LAT+1 cycles.
  - Undefined: fetch has strict priority.

## Structure
- Package `vga_pkg`: FSM state enum (IDLE/ISSUE/DRAIN), default H/V display constants, and the clog2 helper used for `lb_addr` width.
- Sub-module `rd_tag_pipe`: the RD_LAT-deep tag delay line, with a kill input that clears all live bits.

## Test plan
- Reset, then `frame_start` → reads at addresses 0..319, then `lb_we` on bank 0 at indices 0..319; `fetch_busy` low 323 cycles after the pulse.
- `line_start` with k=0 → `disp_bank`=0, reads at 320..639 into bank 1; the next `line_start` gives `disp_bank`=1 and a fetch into bank 0.
- `wr_valid` held during a fetch:
  - Without `FB_ARB_FAIR_EN`, `wr_ready`=0 until ISSUE ends.
  - With it, grants alternate and fetch takes ≤643 cycles.
- `line_start` 100 cycles into a fetch → `underrun` pulses once; no `lb_we` from killed reads; the new line restarts at w=0.
- `line_start` at k=V_DISP-1 → no reads; `frame_start` and `line_start` in the same cycle → fetch of line 0 only.
- `rst_n` low mid-ISSUE → all outputs 0 immediately; nothing resumes until `frame_start`.
